// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline datapath.
// With HAZ_PERF_CNT_EN defined the bundle also carries the stall-cycle counter.
interface hazard_stall_ctrl_if
`ifdef HAZ_PERF_CNT_EN
  #(parameter int unsigned PERF_W = 32)
`endif
  ;
  logic [4:0] IDRegRs_i;
  logic [4:0] IDRegRt_i;
  logic       IDUseRt_i;
  logic       IDBranch_i;
  logic       BranchTaken_i;
  logic [4:0] EXRegRd_i;
  logic       EXRegWrite_i;
  logic       EXMemRead_i;
  logic [4:0] MEMRegRd_i;
  logic       MEMMemRead_i;
  logic       MemBusy_i;

  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       IFIDFlush_o;
  logic       IDEXBubble_o;
  logic       PipeFreeze_o;
`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] StallCycles_o;
`endif

  modport master (
    output IDRegRs_i, IDRegRt_i, IDUseRt_i, IDBranch_i, BranchTaken_i,
           EXRegRd_i, EXRegWrite_i, EXMemRead_i, MEMRegRd_i, MEMMemRead_i, MemBusy_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o
`ifdef HAZ_PERF_CNT_EN
    , input StallCycles_o
`endif
  );

  modport slave (
    input  IDRegRs_i, IDRegRt_i, IDUseRt_i, IDBranch_i, BranchTaken_i,
           EXRegRd_i, EXRegWrite_i, EXMemRead_i, MEMRegRd_i, MEMMemRead_i, MemBusy_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeFreeze_o
`ifdef HAZ_PERF_CNT_EN
    , output StallCycles_o
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detection and stall/flush control for the 5-stage MIPS pipeline.
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W = 2
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input logic               clk_i,
  input logic               rst_i,
  hazard_stall_ctrl_if.slave hz
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] STALL  = 2'd1;
  localparam logic [1:0] FREEZE = 2'd2;

  logic [1:0]       state, nState;
  logic [1:0]       savedState, nSaved;
  logic [CNT_W-1:0] cnt, nCnt;
  logic [1:0]       runState;

  logic       mex, mmem;
  logic [1:0] stallLen;

  logic pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze;

  always_comb begin
    mex  = hz.EXRegWrite_i && (hz.EXRegRd_i != 5'd0) &&
           ((hz.EXRegRd_i == hz.IDRegRs_i) || (hz.IDUseRt_i && (hz.EXRegRd_i == hz.IDRegRt_i)));
    mmem = hz.MEMMemRead_i && (hz.MEMRegRd_i != 5'd0) &&
           ((hz.MEMRegRd_i == hz.IDRegRs_i) || (hz.IDUseRt_i && (hz.MEMRegRd_i == hz.IDRegRt_i)));
  end

  // Longest required stall wins: load feeding a branch needs two cycles.
  always_comb begin
    stallLen = 2'd0;
    if (hz.EXMemRead_i && mex && hz.IDBranch_i)
      stallLen = 2'd2;
    else if ((hz.EXMemRead_i && mex) || (hz.IDBranch_i && mex) || (hz.IDBranch_i && mmem))
      stallLen = 2'd1;
  end

  // FREEZE resumes the saved state in the same cycle it is released.
  assign runState = (state == FREEZE) ? savedState : state;

  always_comb begin
    nState     = state;
    nSaved     = savedState;
    nCnt       = cnt;
    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    ifidFlush  = 1'b0;
    idexBubble = 1'b1;
    pipeFreeze = 1'b0;

    if (!rst_i) begin
      nState = RUN;
      nSaved = RUN;
      nCnt   = '0;
    end else if (hz.MemBusy_i) begin
      idexBubble = 1'b0;
      pipeFreeze = 1'b1;
      nState     = FREEZE;
      nSaved     = runState;
    end else if (runState == RUN) begin
      if (stallLen != 2'd0) begin
        if (stallLen == 2'd2) begin
          nState = STALL;
          nCnt   = CNT_W'(1);
        end else begin
          nState = RUN;
        end
      end else begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexBubble = 1'b0;
        ifidFlush  = hz.IDBranch_i && hz.BranchTaken_i;
        nState     = RUN;
      end
    end else begin
      nCnt   = cnt - CNT_W'(1);
      nState = (cnt == CNT_W'(1)) ? RUN : STALL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= RUN;
      savedState <= RUN;
      cnt        <= '0;
    end else begin
      state      <= nState;
      savedState <= nSaved;
      cnt        <= nCnt;
    end
  end

  assign hz.PCWrite_o    = pcWrite;
  assign hz.IFIDWrite_o  = ifidWrite;
  assign hz.IFIDFlush_o  = ifidFlush;
  assign hz.IDEXBubble_o = idexBubble;
  assign hz.PipeFreeze_o = pipeFreeze;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stallCycles;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stallCycles <= '0;
    else if (!pcWrite)
      stallCycles <= stallCycles + PERF_W'(1);
  end

  assign hz.StallCycles_o = stallCycles;
`endif

  aSavedNotFreeze: assert property (@(posedge clk_i) disable iff (!rst_i)
    savedState != FREEZE);
  aStallCntLive: assert property (@(posedge clk_i) disable iff (!rst_i)
    (runState == STALL) |-> (cnt != '0));
  aFreezeHoldsPc: assert property (@(posedge clk_i) disable iff (!rst_i)
    pipeFreeze |-> (!pcWrite && !ifidFlush));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a remaining-stall-count model checked every
// cycle, plus hand-computed expectations from the hazard scenarios.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  hazard_stall_ctrl_if #(.PERF_W(32)) bus();
  hazard_stall_ctrl #(.CNT_W(2), .PERF_W(32)) dut (.clk_i(clk), .rst_i(rst), .hz(bus));
`else
  hazard_stall_ctrl_if bus();
  hazard_stall_ctrl #(.CNT_W(2)) dut (.clk_i(clk), .rst_i(rst), .hz(bus));
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic pcw;
    logic ifidw;
    logic flush;
    logic bubble;
    logic freeze;
  } outs_t;

  // Model state: bubble cycles still owed, and stall cycles seen since reset.
  int          pending = 0;
  logic [31:0] perfM   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  function automatic bit hits(input logic [4:0] rd);
    return (rd != 0) && (rd == bus.IDRegRs_i || (bus.IDUseRt_i && rd == bus.IDRegRt_i));
  endfunction

  function automatic int needN();
    int n;
    bit mex, mmem;
    n    = 0;
    mex  = bus.EXRegWrite_i && hits(bus.EXRegRd_i);
    mmem = bus.MEMMemRead_i && hits(bus.MEMRegRd_i);
    if (bus.IDBranch_i && mmem) n = 1;
    if (mex && (bus.EXMemRead_i || bus.IDBranch_i)) n = 1;
    if (mex && bus.EXMemRead_i && bus.IDBranch_i) n = 2;
    return n;
  endfunction

  function automatic outs_t expOuts();
    outs_t o;
    o = '0;
    if (!rst) o.bubble = 1'b1;
    else if (bus.MemBusy_i) o.freeze = 1'b1;
    else if (pending > 0 || needN() > 0) o.bubble = 1'b1;
    else begin
      o.pcw   = 1'b1;
      o.ifidw = 1'b1;
      o.flush = bus.IDBranch_i && bus.BranchTaken_i;
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst) begin
    outs_t e;
    if (!rst) begin
      pending <= 0;
      perfM   <= '0;
    end else begin
      e = expOuts();
      if (!bus.MemBusy_i) begin
        if (pending > 0) pending <= pending - 1;
        else if (needN() > 0) pending <= needN() - 1;
      end
      if (!e.pcw) perfM <= perfM + 32'd1;
    end
  end

  always @(negedge clk) begin
    outs_t e;
    e = expOuts();
    chk("mdl_PCWrite",    {31'd0, bus.PCWrite_o},    {31'd0, e.pcw});
    chk("mdl_IFIDWrite",  {31'd0, bus.IFIDWrite_o},  {31'd0, e.ifidw});
    chk("mdl_IFIDFlush",  {31'd0, bus.IFIDFlush_o},  {31'd0, e.flush});
    chk("mdl_IDEXBubble", {31'd0, bus.IDEXBubble_o}, {31'd0, e.bubble});
    chk("mdl_PipeFreeze", {31'd0, bus.PipeFreeze_o}, {31'd0, e.freeze});
`ifdef HAZ_PERF_CNT_EN
    chk("mdl_StallCycles", bus.StallCycles_o, perfM);
`endif
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.IDRegRs_i = '0; bus.IDRegRt_i = '0; bus.IDUseRt_i = 1'b0;
    bus.IDBranch_i = 1'b0; bus.BranchTaken_i = 1'b0;
    bus.EXRegRd_i = '0; bus.EXRegWrite_i = 1'b0; bus.EXMemRead_i = 1'b0;
    bus.MEMRegRd_i = '0; bus.MEMMemRead_i = 1'b0; bus.MemBusy_i = 1'b0;
  endtask

  task automatic setEx(input logic wr, input logic ld, input logic [4:0] rd);
    bus.EXRegWrite_i = wr; bus.EXMemRead_i = ld; bus.EXRegRd_i = rd;
  endtask

  task automatic setMem(input logic ld, input logic [4:0] rd);
    bus.MEMMemRead_i = ld; bus.MEMRegRd_i = rd;
  endtask

  task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic useRt,
                       input logic br, input logic tk);
    bus.IDRegRs_i = rs; bus.IDRegRt_i = rt; bus.IDUseRt_i = useRt;
    bus.IDBranch_i = br; bus.BranchTaken_i = tk;
  endtask

  task automatic lit(input string nm, input logic act, input logic req);
    chk(nm, {31'd0, act}, {31'd0, req});
  endtask

  typedef struct packed {
    logic exWr; logic exLd; logic [4:0] exRd;
    logic memLd; logic [4:0] memRd;
    logic [4:0] rs; logic [4:0] rt; logic useRt; logic br; logic tk;
    logic pcw;
  } vec_t;

  vec_t vecs [7];
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] p0;
`endif

  initial begin
    vecs[0] = '{exWr:0, exLd:0, exRd:0,  memLd:1, memRd:8, rs:8,  rt:0,  useRt:0, br:1, tk:1, pcw:0};
    vecs[1] = '{exWr:0, exLd:0, exRd:0,  memLd:1, memRd:8, rs:8,  rt:0,  useRt:0, br:0, tk:0, pcw:1};
    vecs[2] = '{exWr:1, exLd:0, exRd:9,  memLd:0, memRd:0, rs:9,  rt:0,  useRt:0, br:0, tk:0, pcw:1};
    vecs[3] = '{exWr:1, exLd:0, exRd:9,  memLd:0, memRd:0, rs:1,  rt:9,  useRt:0, br:1, tk:0, pcw:1};
    vecs[4] = '{exWr:1, exLd:1, exRd:10, memLd:0, memRd:0, rs:1,  rt:10, useRt:1, br:0, tk:0, pcw:0};
    vecs[5] = '{exWr:0, exLd:0, exRd:11, memLd:0, memRd:0, rs:11, rt:0,  useRt:0, br:1, tk:1, pcw:1};
    vecs[6] = '{exWr:0, exLd:0, exRd:0,  memLd:1, memRd:0, rs:0,  rt:0,  useRt:1, br:1, tk:0, pcw:1};

    clr();
    rst = 1'b0;
    @(negedge clk);
    lit("rst_PCWrite", bus.PCWrite_o, 1'b0);
    lit("rst_IDEXBubble", bus.IDEXBubble_o, 1'b1);
    lit("rst_PipeFreeze", bus.PipeFreeze_o, 1'b0);
    nxt(); rst = 1'b1;
    @(negedge clk); lit("idle_PCWrite", bus.PCWrite_o, 1'b1);

    // Load-use into a non-branch: single bubble.
    nxt(); clr(); setEx(1, 1, 5'd2); setId(5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    lit("lu_PCWrite", bus.PCWrite_o, 1'b0);
    lit("lu_IDEXBubble", bus.IDEXBubble_o, 1'b1);
    nxt(); clr(); setMem(1, 5'd2); setId(5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); lit("lu_after_PCWrite", bus.PCWrite_o, 1'b1);

    // Load feeding a taken branch: two stall cycles, flush only afterwards.
    nxt(); clr(); setEx(1, 1, 5'd3); setId(5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    lit("lb_c1_PCWrite", bus.PCWrite_o, 1'b0);
    lit("lb_c1_Flush", bus.IFIDFlush_o, 1'b0);
    nxt(); clr(); setMem(1, 5'd3); setId(5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    lit("lb_c2_PCWrite", bus.PCWrite_o, 1'b0);
    lit("lb_c2_Flush", bus.IFIDFlush_o, 1'b0);
    lit("lb_c2_Bubble", bus.IDEXBubble_o, 1'b1);
    nxt(); clr(); setId(5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    lit("lb_c3_Flush", bus.IFIDFlush_o, 1'b1);
    lit("lb_c3_PCWrite", bus.PCWrite_o, 1'b1);

    // ALU result into branch rt: one cycle, no counter load; register 0 never matches.
    nxt(); clr(); setEx(1, 0, 5'd4); setId(5'd7, 5'd4, 1'b1, 1'b1, 1'b0);
    @(negedge clk); lit("ab_c1_PCWrite", bus.PCWrite_o, 1'b0);
    nxt(); clr(); setId(5'd7, 5'd4, 1'b1, 1'b1, 1'b0);
    @(negedge clk); lit("ab_c2_PCWrite", bus.PCWrite_o, 1'b1);
    nxt(); clr(); setEx(1, 0, 5'd0); setId(5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    lit("r0_PCWrite", bus.PCWrite_o, 1'b1);
    lit("r0_Flush", bus.IFIDFlush_o, 1'b1);
    nxt(); clr(); setEx(1, 1, 5'd0); setId(5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lit("ld0_PCWrite", bus.PCWrite_o, 1'b1);

    // Memory wait in the middle of a two-cycle stall.
    nxt(); clr(); setEx(1, 1, 5'd5); setId(5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    lit("fz_c1_PCWrite", bus.PCWrite_o, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    p0 = bus.StallCycles_o;
`endif
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.MemBusy_i = 1'b1;
      @(negedge clk);
      lit("fz_Freeze", bus.PipeFreeze_o, 1'b1);
      lit("fz_PCWrite", bus.PCWrite_o, 1'b0);
      lit("fz_Bubble", bus.IDEXBubble_o, 1'b0);
    end
    nxt(); bus.MemBusy_i = 1'b0;
    @(negedge clk);
    lit("fz_stall_Freeze", bus.PipeFreeze_o, 1'b0);
    lit("fz_stall_PCWrite", bus.PCWrite_o, 1'b0);
    lit("fz_stall_Bubble", bus.IDEXBubble_o, 1'b1);
    nxt(); clr(); setId(5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    lit("fz_run_PCWrite", bus.PCWrite_o, 1'b1);
`ifdef HAZ_PERF_CNT_EN
    chk("fz_StallCycles", bus.StallCycles_o, p0 + 32'd5);
`endif

    // Asynchronous reset in the middle of STALL.
    nxt(); clr(); setEx(1, 1, 5'd6); setId(5'd6, 5'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk); lit("ar_c1_PCWrite", bus.PCWrite_o, 1'b0);
    @(posedge clk); #3; rst = 1'b0; #1;
    lit("ar_PCWrite", bus.PCWrite_o, 1'b0);
    lit("ar_Bubble", bus.IDEXBubble_o, 1'b1);
    lit("ar_IFIDWrite", bus.IFIDWrite_o, 1'b0);
`ifdef HAZ_PERF_CNT_EN
    chk("ar_StallCycles", bus.StallCycles_o, 32'd0);
`endif
    nxt(); clr(); rst = 1'b1;
    @(negedge clk);
    lit("ar_rel_PCWrite", bus.PCWrite_o, 1'b1);
`ifdef HAZ_PERF_CNT_EN
    chk("ar_rel_StallCycles", bus.StallCycles_o, 32'd0);
`endif

    // Taken branch without hazards, then the same under a memory wait.
    nxt(); clr(); setId(5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    lit("tb_Flush", bus.IFIDFlush_o, 1'b1);
    lit("tb_PCWrite", bus.PCWrite_o, 1'b1);
    lit("tb_Bubble", bus.IDEXBubble_o, 1'b0);
    nxt(); bus.MemBusy_i = 1'b1;
    @(negedge clk);
    lit("tbb_Flush", bus.IFIDFlush_o, 1'b0);
    lit("tbb_Freeze", bus.PipeFreeze_o, 1'b1);
    nxt(); clr();
    @(negedge clk); lit("tbb_after_PCWrite", bus.PCWrite_o, 1'b1);

    // Assorted single-cycle hazard patterns, each followed by a quiet cycle.
    foreach (vecs[i]) begin
      nxt(); clr();
      setEx(vecs[i].exWr, vecs[i].exLd, vecs[i].exRd);
      setMem(vecs[i].memLd, vecs[i].memRd);
      setId(vecs[i].rs, vecs[i].rt, vecs[i].useRt, vecs[i].br, vecs[i].tk);
      @(negedge clk); lit($sformatf("vec%0d_PCWrite", i), bus.PCWrite_o, vecs[i].pcw);
      nxt(); clr();
      @(negedge clk);
    end

    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
